// File: rtl/dtw_traceback.sv
// DTW traceback: stores per-cell path codes from a 6-lane systolic array and walks them back from (tlast,rlast) to (0,0).
// Latency: first step is valid the cycle after i_start is sampled; one step per accepted handshake thereafter.
// Backpressure: step outputs hold while i_step_rdy is low or ena is low; path writes are accepted only while idle.
module dtw_traceback (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ena,
  input  logic        i_wr_vld,
  input  logic [5:0]  i_lane_en,
  input  logic [11:0] i_path,
  input  logic [29:0] i_tindex,
  input  logic [29:0] i_rindex,
  input  logic        i_start,
  input  logic [4:0]  i_tlast,
  input  logic [4:0]  i_rlast,
  input  logic        i_step_rdy,
  output logic        o_step_vld,
  output logic [4:0]  o_step_t,
  output logic [4:0]  o_step_r,
  output logic [1:0]  o_step_dir,
  output logic        o_step_last,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] DIR_DIAG = 2'b00;
  localparam logic [1:0] DIR_T    = 2'b01;
  localparam logic [1:0] DIR_R    = 2'b10;
  localparam logic [1:0] DIR_END  = 2'b11;

  logic [1:0] state;
  logic [4:0] cur_t;
  logic [4:0] cur_r;
  logic       err;
  logic [1:0] store [0:31][0:31];

  logic [1:0] lane_path [0:5];
  logic [4:0] lane_t    [0:5];
  logic [4:0] lane_r    [0:5];
  logic       lane_we   [0:5];

  logic       tracing;
  logic       accept;
  logic       at_origin;
  logic       illegal;
  logic [1:0] stored;
  logic [1:0] dir;

  // Unpack the lane buses; lane 0 sits in the most significant slice of each bus.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      lane_we[k]   = i_lane_en[5-k];
      lane_path[k] = i_path[11-2*k -: 2];
      lane_t[k]    = i_tindex[29-5*k -: 5];
      lane_r[k]    = i_rindex[29-5*k -: 5];
    end
  end

  // Effective move from the current cell: boundaries force the only legal move, illegal codes fall back to diagonal.
  always_comb begin
    tracing   = (state == S_TRACE);
    accept    = tracing && i_step_rdy && ena;
    at_origin = (cur_t == 5'd0) && (cur_r == 5'd0);
    stored    = store[cur_t][cur_r];
    illegal   = 1'b0;
    if (at_origin) begin
      dir = DIR_END;
    end else if (cur_t == 5'd0) begin
      dir = DIR_R;
    end else if (cur_r == 5'd0) begin
      dir = DIR_T;
    end else if (stored == 2'b11) begin
      dir     = DIR_DIAG;
      illegal = 1'b1;
    end else begin
      dir = stored;
    end
  end

  // Path store; later lanes overwrite earlier ones so the highest-numbered lane wins a shared cell.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 32; i++) begin
        for (int j = 0; j < 32; j++) begin
          store[i][j] <= 2'b00;
        end
      end
    end else if (ena && (state == S_IDLE) && i_wr_vld) begin
      for (int k = 0; k < 6; k++) begin
        if (lane_we[k]) begin
          store[lane_t[k]][lane_r[k]] <= lane_path[k];
        end
      end
    end
  end

  // Control FSM, current cell and sticky error flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      cur_t <= 5'd0;
      cur_r <= 5'd0;
      err   <= 1'b0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            cur_t <= i_tlast;
            cur_r <= i_rlast;
            err   <= 1'b0;
            state <= S_TRACE;
          end
        end
        S_TRACE: begin
          if (accept) begin
            if (illegal) begin
              err <= 1'b1;
            end
            if (at_origin) begin
              state <= S_DONE;
            end else begin
              if (dir != DIR_R) begin
                cur_t <= cur_t - 5'd1;
              end
              if (dir != DIR_T) begin
                cur_r <= cur_r - 5'd1;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_step_vld  = tracing;
  assign o_busy      = tracing;
  assign o_done      = (state == S_DONE);
  assign o_err       = err;
  assign o_step_t    = cur_t;
  assign o_step_r    = cur_r;
  assign o_step_dir  = tracing ? dir : 2'b00;
  assign o_step_last = tracing && at_origin;

endmodule

// File: tb/tb_dtw_traceback.sv
// Bench for dtw_traceback: reference path store plus trace walker feeding a step scoreboard.
// Stimulus is driven 1 time unit after the rising edge; the monitor samples on the falling edge.
// Backpressure and enable gaps are exercised; held outputs are checked while steps are not accepted.
module tb_dtw_traceback;

  typedef struct packed {
    logic [4:0] t;
    logic [4:0] r;
    logic [1:0] dir;
    logic       last;
  } step_t;

  logic        clk;
  logic        nrst;
  logic        ena;
  logic        i_wr_vld;
  logic [5:0]  i_lane_en;
  logic [11:0] i_path;
  logic [29:0] i_tindex;
  logic [29:0] i_rindex;
  logic        i_start;
  logic [4:0]  i_tlast;
  logic [4:0]  i_rlast;
  logic        i_step_rdy;
  logic        o_step_vld;
  logic [4:0]  o_step_t;
  logic [4:0]  o_step_r;
  logic [1:0]  o_step_dir;
  logic        o_step_last;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int    checks;
  int    errors;
  int    start_cnt;
  int    seen_start;
  int    done_cnt;
  step_t exp_q [$];
  logic [1:0] mem [0:31][0:31];

  dtw_traceback dut (
    .clk(clk), .nrst(nrst), .ena(ena), .i_wr_vld(i_wr_vld), .i_lane_en(i_lane_en),
    .i_path(i_path), .i_tindex(i_tindex), .i_rindex(i_rindex), .i_start(i_start),
    .i_tlast(i_tlast), .i_rlast(i_rlast), .i_step_rdy(i_step_rdy),
    .o_step_vld(o_step_vld), .o_step_t(o_step_t), .o_step_r(o_step_r),
    .o_step_dir(o_step_dir), .o_step_last(o_step_last), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected steps on every accepted handshake and checks hold / done behaviour.
  bit         hold;
  bit         pend_done;
  logic [4:0] h_t, h_r;
  logic [1:0] h_dir;
  always @(negedge clk) begin
    step_t e;
    if (!nrst) begin
      hold      = 1'b0;
      pend_done = 1'b0;
    end else begin
      if (pend_done) begin
        chk("done_pulse", o_done, 1);
        pend_done = 1'b0;
        done_cnt++;
      end else begin
        chk("no_done", o_done, 0);
      end
      if (hold) begin
        chk("hold_t", o_step_t, h_t);
        chk("hold_r", o_step_r, h_r);
        chk("hold_dir", o_step_dir, h_dir);
      end
      if (o_step_vld && seen_start != start_cnt) begin
        seen_start = start_cnt;
        chk("err_cleared", o_err, 0);
      end
      if (o_step_vld && i_step_rdy && ena) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_step t=%0d r=%0d dir=%0d", o_step_t, o_step_r, o_step_dir);
        end else begin
          e = exp_q.pop_front();
          chk("step_t", o_step_t, e.t);
          chk("step_r", o_step_r, e.r);
          chk("step_dir", o_step_dir, e.dir);
          chk("step_last", o_step_last, e.last);
          if (e.last) pend_done = 1'b1;
        end
      end
      hold  = o_step_vld && !(i_step_rdy && ena);
      h_t   = o_step_t;
      h_r   = o_step_r;
      h_dir = o_step_dir;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_writes();
    i_wr_vld  = 1'b0;
    i_lane_en = '0;
    i_path    = '0;
    i_tindex  = '0;
    i_rindex  = '0;
  endtask

  task automatic drive_lane(input int k, input logic [4:0] t, input logic [4:0] r, input logic [1:0] c);
    i_lane_en[5-k]       = 1'b1;
    i_path[11-2*k -: 2]  = c;
    i_tindex[29-5*k -: 5] = t;
    i_rindex[29-5*k -: 5] = r;
  endtask

  task automatic rand_lanes(input int tmax, input int rmax);
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1)
        drive_lane(k, 5'($urandom_range(0, tmax)), 5'($urandom_range(0, rmax)), 2'($urandom_range(0, 3)));
    end
  endtask

  // Present the staged lanes as a write and apply them to the reference store in lane order.
  task automatic stage_writes();
    i_wr_vld = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (i_lane_en[5-k])
        mem[i_tindex[29-5*k -: 5]][i_rindex[29-5*k -: 5]] = i_path[11-2*k -: 2];
    end
  endtask

  task automatic write_cycle();
    stage_writes();
    tick();
    clear_writes();
  endtask

  task automatic fill(input int tmax, input int rmax, input logic [1:0] c);
    int k;
    k = 0;
    for (int t = 0; t <= tmax; t++) begin
      for (int r = 0; r <= rmax; r++) begin
        drive_lane(k, 5'(t), 5'(r), c);
        k++;
        if (k == 6) begin
          write_cycle();
          k = 0;
        end
      end
    end
    if (k != 0) write_cycle();
  endtask

  // mode 0: always ready; 1: random ready; 2: ready 1,0,0,1 pattern with an enable gap; 3: ready with writes during trace.
  task automatic run_trace(input logic [4:0] tl, input logic [4:0] rl, input int mode);
    step_t      e;
    logic [4:0] t, r;
    logic [1:0] c;
    bit         ee;
    int         d0;
    ee = 1'b0;
    t  = tl;
    r  = rl;
    for (int n = 0; n < 70; n++) begin
      e.t = t;
      e.r = r;
      e.last = 1'b0;
      if (t == 0 && r == 0) begin
        e.dir = 2'b11;
        e.last = 1'b1;
      end else if (t == 0) begin
        e.dir = 2'b10;
      end else if (r == 0) begin
        e.dir = 2'b01;
      end else begin
        c = mem[t][r];
        if (c == 2'b11) begin
          ee = 1'b1;
          e.dir = 2'b00;
        end else begin
          e.dir = c;
        end
      end
      exp_q.push_back(e);
      if (e.last) break;
      if (e.dir != 2'b10) t = t - 5'd1;
      if (e.dir != 2'b01) r = r - 5'd1;
    end
    d0 = done_cnt;
    i_tlast = tl;
    i_rlast = rl;
    i_start = 1'b1;
    i_step_rdy = 1'b0;
    start_cnt++;
    tick();
    i_start = 1'b0;
    clear_writes();
    chk("vld_after_start", o_step_vld, 1);
    chk("busy_after_start", o_busy, 1);
    for (int cyc = 0; cyc < 300 && done_cnt == d0; cyc++) begin
      ena = 1'b1;
      case (mode)
        1: i_step_rdy = 1'($urandom_range(0, 1));
        2: begin
          i_step_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
          ena = !(cyc == 5 || cyc == 6);
        end
        3: begin
          i_step_rdy = 1'b1;
          clear_writes();
          rand_lanes(5, 5);
          i_wr_vld = 1'b1;
        end
        default: i_step_rdy = 1'b1;
      endcase
      tick();
    end
    ena = 1'b1;
    i_step_rdy = 1'b0;
    clear_writes();
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL trace_timeout tl=%0d rl=%0d remaining=%0d", tl, rl, exp_q.size());
      exp_q.delete();
    end
    chk("err_flag", o_err, ee);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_after_done", o_busy, 0);
  endtask

  initial begin
    checks = 0; errors = 0; start_cnt = 0; seen_start = 0; done_cnt = 0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        mem[i][j] = 2'b00;
    nrst = 1'b0; ena = 1'b1; i_start = 1'b0; i_tlast = '0; i_rlast = '0; i_step_rdy = 1'b0;
    clear_writes();
    tick();
    tick();
    chk("rst_vld", o_step_vld, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_t", o_step_t, 0);
    chk("rst_r", o_step_r, 0);
    chk("rst_dir", o_step_dir, 0);
    chk("rst_last", o_step_last, 0);
    nrst = 1'b1;

    // All-diagonal 4x4 store traced from the far corner.
    fill(3, 3, 2'b00);
    run_trace(5'd3, 5'd3, 0);

    // All "from T" codes: walk up column then forced moves along the t=0 edge.
    fill(2, 3, 2'b01);
    run_trace(5'd2, 5'd3, 0);

    // Illegal code written in the same cycle as start; error stays set while idle.
    drive_lane(2, 5'd2, 5'd2, 2'b11);
    stage_writes();
    run_trace(5'd2, 5'd2, 0);
    tick();
    tick();
    chk("err_sticky", o_err, 1);

    // Backpressure pattern with an enable gap mid-trace.
    run_trace(5'd5, 5'd5, 2);

    // Lane conflict on one cell, then writes during a trace must not land.
    drive_lane(1, 5'd5, 5'd5, 2'b01);
    drive_lane(4, 5'd5, 5'd5, 2'b10);
    write_cycle();
    run_trace(5'd5, 5'd5, 3);
    run_trace(5'd5, 5'd5, 0);

    // Origin-only trace.
    run_trace(5'd0, 5'd0, 0);

    // Reset in the middle of a stalled trace.
    fill(4, 4, 2'b01);
    i_tlast = 5'd4; i_rlast = 5'd4; i_start = 1'b1;
    start_cnt++;
    tick();
    i_start = 1'b0;
    tick();
    nrst = 1'b0;
    #1;
    chk("midrst_vld", o_step_vld, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_t", o_step_t, 0);
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        mem[i][j] = 2'b00;
    exp_q.delete();
    tick();
    nrst = 1'b1;
    run_trace(5'd4, 5'd4, 0);

    // Randomized stores and traces.
    for (int it = 0; it < 25; it++) begin
      int tl, rl;
      tl = $urandom_range(0, 9);
      rl = $urandom_range(0, 9);
      for (int w = 0; w < 10; w++) begin
        rand_lanes(9, 9);
        write_cycle();
      end
      run_trace(5'(tl), 5'(rl), $urandom_range(0, 3));
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtw_traceback.md
DTW_TRACEBACK -- requirements
Module: dtw_traceback

Interface
REQ-001 Parameters: none; geometry fixed at 6 lanes, 5-bit indices (sequences up to 32), 2-bit path codes.
REQ-002 clk  input  1  single system clock, rising edge.
REQ-003 nrst  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  global enable; when low all state, including outputs, holds.
REQ-005 i_wr_vld  input  1  path-write strobe from the systolic array.
REQ-006 i_lane_en  input  6  per-lane write enable; bit 5 = lane 0.
REQ-007 i_path  input  12  lane k code at [11-2k:10-2k].
REQ-008 i_tindex  input  30  lane k T index at [29-5k:25-5k].
REQ-009 i_rindex  input  30  lane k R index at [29-5k:25-5k].
REQ-010 i_start  input  1  begin traceback.
REQ-011 i_tlast, i_rlast  input  5 each  end coordinates of the trace.
REQ-012 i_step_rdy  input  1  consumer ready for step output.
REQ-013 o_step_vld  output  1  step valid.
REQ-014 o_step_t, o_step_r  output  5 each  current cell coordinates.
REQ-015 o_step_dir  output  2  effective move from current cell.
REQ-016 o_step_last  output  1  current step is cell (0,0).
REQ-017 o_busy  output  1  high in TRACE.
REQ-018 o_done  output  1  one-cycle pulse after final step accepted.
REQ-019 o_err  output  1  sticky illegal-code flag.

Function
REQ-020 Path store SHALL be 32x32 entries of 2 bits, indexed [t][r]; codes: 00 diagonal (t-1,r-1), 01 from T (t-1,r), 10 from R (t,r-1), 11 illegal.
REQ-021 FSM states SHALL be IDLE, TRACE, DONE; all transitions gated by ena.
REQ-022 In IDLE with i_wr_vld=1, each lane with i_lane_en bit set SHALL write its code to [tindex][rindex] at the clock edge; on same-cell conflict the highest-numbered lane wins.
REQ-023 Writes in TRACE or DONE SHALL be ignored.
REQ-024 IDLE + i_start: latch cur=(i_tlast,i_rlast), clear o_err, go TRACE; a write in the same cycle SHALL be visible to the trace.
REQ-025 o_step_vld SHALL assert the cycle after i_start is sampled and stay high throughout TRACE.
REQ-026 o_step_dir: t=0 and r>0 -> 10; r=0 and t>0 -> 01; t=r=0 -> 11 with o_step_last=1; otherwise stored code, with 11 replaced by 00.
REQ-027 Stored code 11 at a non-origin, non-boundary cell SHALL set o_err when that step is accepted.
REQ-028 On o_step_vld & i_step_rdy & ena, cur SHALL update per o_step_dir; outputs SHALL be stable while i_step_rdy is low.
REQ-029 Acceptance of the last step SHALL go to DONE; DONE SHALL pulse o_done for one cycle and return to IDLE.
REQ-030 i_start outside IDLE SHALL be ignored.
REQ-031 Trace length SHALL be at most tlast+rlast+1 steps; one step per cycle under continuous ready.

Reset
REQ-032 nrst low SHALL asynchronously force IDLE, cur=(0,0), path store to 00, and all outputs to 0, including mid-trace.
REQ-033 The first operation after reset release SHALL be accepted on the first enabled edge.

Verification
REQ-034 Fill a 4x4 store with all 00, start (3,3), rdy=1 -> steps (3,3),(2,2),(1,1),(0,0), dirs 00,00,00,11, last on step 4, o_done next cycle.
REQ-035 Store all 01, start (2,3) -> (2,3),(1,3),(0,3) then forced 10 to (0,2),(0,1),(0,0); 6 steps; o_err=0.
REQ-036 Start (2,2) with code 11 at (2,2) -> dir 00, o_err=1 after accept, stays 1 until next start.
REQ-037 Toggle i_step_rdy 1,0,0,1 -> coordinates held during low cycles; ena=0 for 2 cycles mid-trace -> no advance.
REQ-038 Two lanes write (5,5) with 01 and 10 same cycle -> lane with higher number's code stored; write during TRACE leaves store unchanged.
REQ-039 nrst low mid-trace -> o_step_vld=0 and o_busy=0 immediately; next trace over an unwritten store yields all-diagonal steps.
